ibi_sched: RTL and testbench

Target-side scheduler for in-band interrupts and Hot-Join requests. It decides when the IBI FSM and the Hot-Join FSM may start, holds their begin strobes, and waits for their done pulses. Between failed attempts it enforces a programmable holdoff, and it counts consecutive failures. It sits between the TTI/CSR layer and the target-initiated bus-start FSMs in the controller's target path.

---
 rtl/i3c_pkg.sv | 18 +
 rtl/ibi_sched_holdoff_timer.sv | 26 ++
 rtl/ibi_sched.sv | 129 ++++++++++++
 tb/tb_ibi_sched.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/i3c_pkg.sv
// Shared I3C target-path types: IBI FSM status codes and the IBI scheduler state encoding.
package i3c_pkg;

   typedef enum logic [1:0] {
      IbiSuccess   = 2'b00,
      IbiNack      = 2'b01,
      IbiPartial   = 2'b10,
      IbiRetryFail = 2'b11
   } ibi_status_e;

   typedef enum logic [1:0] {
      Idle      = 2'b00,
      IbiActive = 2'b01,
      HjActive  = 2'b10,
      Holdoff   = 2'b11
   } ibi_sched_state_e;

endpackage

// File: rtl/ibi_sched_holdoff_timer.sv
// Down-counter for the post-failure holdoff: loads on entry, counts to zero, then holds.
module holdoff_timer #(
   parameter int unsigned HoldoffW = 20
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                load,
   input  logic [HoldoffW-1:0] value,
   output logic                expired
);

   logic [HoldoffW-1:0] count;

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= value;
      end else if (count != '0) begin
         count <= count - HoldoffW'(1);
      end
   end

   assign expired = (count == '0);

endmodule

// File: rtl/ibi_sched.sv
// Target-side IBI / Hot-Join start scheduler with failure holdoff and attempt counting.
// Hot-Join support is compiled in only when I3C_HOTJOIN_EN is defined.
module ibi_sched
   import i3c_pkg::*;
#(
   parameter int unsigned HoldoffW = 20,
   parameter int unsigned AttemptW = 8
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                ibi_enable_i,
   input  logic                hj_enable_i,
   input  logic                dyn_addr_valid_i,
   input  logic                ibi_pending_i,
   input  logic                hj_req_i,
   input  logic                abort_i,
   input  logic [HoldoffW-1:0] holdoff_cycles_i,
   output logic                ibi_begin_o,
   input  logic                ibi_done_i,
   input  logic [1:0]          ibi_status_i,
   output logic                hj_begin_o,
   input  logic                hj_done_i,
   output logic                busy_o,
   output logic [1:0]          last_status_o,
   output logic [AttemptW-1:0] attempts_o,
   output logic                irq_o
);

   ibi_sched_state_e state;
   ibi_sched_state_e nxt_state;
   logic             abort_q;
   logic             abort_any;
   logic             ibi_start;
   logic             hj_start;
   logic             ibi_fin;
   logic             hj_fin;
   logic             ibi_ok;
   logic             hold_load;
   logic             expired;
   logic             hj_begin_q;

   assign abort_any = abort_i | abort_q;
   assign ibi_start = ibi_enable_i & dyn_addr_valid_i & ibi_pending_i;
   assign ibi_fin   = (state == IbiActive) & ibi_done_i;
   assign ibi_ok    = (ibi_status_e'(ibi_status_i) == IbiSuccess);

`ifdef I3C_HOTJOIN_EN
   assign hj_start   = hj_enable_i & hj_req_i & ~dyn_addr_valid_i;
   assign hj_fin     = (state == HjActive) & hj_done_i;
   assign hj_begin_o = hj_begin_q;
`else
   logic unused_hj;
   assign unused_hj  = ^{hj_enable_i, hj_req_i, hj_done_i, hj_begin_q};
   assign hj_start   = 1'b0;
   assign hj_fin     = 1'b0;
   assign hj_begin_o = 1'b0;
`endif

   // Holdoff is entered only from a non-aborted failed IBI or a non-aborted Hot-Join.
   assign hold_load = ~abort_any & (hj_fin | (ibi_fin & ~ibi_ok));

   holdoff_timer #(.HoldoffW(HoldoffW)) u_holdoff_timer (
      .clk     (clk_i),
      .rst     (rst_i),
      .load    (hold_load),
      .value   (holdoff_cycles_i),
      .expired (expired)
   );

   always_comb begin
      nxt_state = state;
      case (state)
         Idle: begin
            if (!abort_i) begin
               if (ibi_start)     nxt_state = IbiActive;
               else if (hj_start) nxt_state = HjActive;
            end
         end
         IbiActive: begin
            if (ibi_done_i) nxt_state = (abort_any || ibi_ok) ? Idle : Holdoff;
         end
         HjActive: begin
            if (hj_fin) nxt_state = abort_any ? Idle : Holdoff;
         end
         Holdoff: begin
            if (abort_i || expired) nxt_state = Idle;
         end
         default: nxt_state = Idle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state         <= Idle;
         abort_q       <= 1'b0;
         ibi_begin_o   <= 1'b0;
         hj_begin_q    <= 1'b0;
         busy_o        <= 1'b0;
         last_status_o <= 2'b00;
         attempts_o    <= '0;
         irq_o         <= 1'b0;
      end else begin
         state       <= nxt_state;
         ibi_begin_o <= (nxt_state == IbiActive);
         hj_begin_q  <= (nxt_state == HjActive);
         busy_o      <= (nxt_state != Idle);
         irq_o       <= ibi_fin;
         if (ibi_fin) last_status_o <= ibi_status_i;

         // An abort is remembered while active and resolved on the done pulse.
         if (ibi_fin || hj_fin) begin
            abort_q <= 1'b0;
         end else if (abort_i && (state == IbiActive || state == HjActive)) begin
            abort_q <= 1'b1;
         end

         if (abort_i && (state == Idle || state == Holdoff)) begin
            attempts_o <= '0;
         end else if (ibi_fin || hj_fin) begin
            if (abort_any || (ibi_fin && ibi_ok)) begin
               attempts_o <= '0;
            end else if (ibi_fin && attempts_o != '1) begin
               attempts_o <= attempts_o + AttemptW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_ibi_sched.sv
// Self-checking bench for ibi_sched: directed scenarios with literal checks, then random
// stimulus compared every cycle against a time-based behavioural model.
module tb_ibi_sched;

   localparam int unsigned HoldoffW = 20;
   localparam int unsigned AttemptW = 2;
   localparam int          MaxAtt   = 3;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                ibi_en = 1'b0, hj_en = 1'b0, dav = 1'b0, pend = 1'b0, hj_req = 1'b0;
   logic                abort = 1'b0, ibi_done = 1'b0, hj_done = 1'b0;
   logic [1:0]          status = 2'b00;
   logic [HoldoffW-1:0] hold = '0;
   logic                ibi_begin, hj_begin, busy, irq;
   logic [1:0]          last_status;
   logic [AttemptW-1:0] attempts;

   ibi_sched #(.HoldoffW(HoldoffW), .AttemptW(AttemptW)) dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .ibi_enable_i     (ibi_en),
      .hj_enable_i      (hj_en),
      .dyn_addr_valid_i (dav),
      .ibi_pending_i    (pend),
      .hj_req_i         (hj_req),
      .abort_i          (abort),
      .holdoff_cycles_i (hold),
      .ibi_begin_o      (ibi_begin),
      .ibi_done_i       (ibi_done),
      .ibi_status_i     (status),
      .hj_begin_o       (hj_begin),
      .hj_done_i        (hj_done),
      .busy_o           (busy),
      .last_status_o    (last_status),
      .attempts_o       (attempts),
      .irq_o            (irq)
   );

   always #5 clk = ~clk;

`ifdef I3C_HOTJOIN_EN
   localparam bit HjOn = 1'b1;
`else
   localparam bit HjOn = 1'b0;
`endif

   // Model: mode 0 idle, 1 IBI active, 2 HJ active, 3 holdoff until cycle idle_at.
   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int m_mode = 0, m_att = 0, m_last = 0, m_irq = 0, m_idle_at = 0;
   bit m_abort = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   // Advance the model by one clock using the inputs currently driven.
   task automatic model_step();
      bit ab;
      m_irq = 0;
      if (rst) begin
         m_mode = 0; m_att = 0; m_last = 0; m_abort = 1'b0;
         return;
      end
      ab = m_abort | abort;
      case (m_mode)
         0: begin
            if (abort) m_att = 0;
            else if (ibi_en && dav && pend) m_mode = 1;
            else if (HjOn && hj_en && hj_req && !dav) m_mode = 2;
         end
         1: begin
            if (ibi_done) begin
               m_last = int'(status); m_irq = 1; m_abort = 1'b0;
               if (ab || status == 2'b00) begin
                  m_mode = 0; m_att = 0;
               end else begin
                  m_mode = 3; m_idle_at = cyc + 2 + int'(hold);
                  m_att = (m_att < MaxAtt) ? m_att + 1 : MaxAtt;
               end
            end else if (abort) m_abort = 1'b1;
         end
         2: begin
            if (hj_done) begin
               m_abort = 1'b0;
               if (ab) begin
                  m_mode = 0; m_att = 0;
               end else begin
                  m_mode = 3; m_idle_at = cyc + 2 + int'(hold);
               end
            end else if (abort) m_abort = 1'b1;
         end
         default: begin
            if (abort) begin
               m_mode = 0; m_att = 0;
            end else if (cyc + 1 >= m_idle_at) m_mode = 0;
         end
      endcase
   endtask

   // One clock: update the model, clock the DUT, then compare everything at the falling edge.
   task automatic tick();
      model_step();
      @(posedge clk);
      cyc++;
      @(negedge clk);
      chk("ibi_begin", int'(ibi_begin), int'(m_mode == 1));
      chk("hj_begin", int'(hj_begin), int'(m_mode == 2));
      chk("busy", int'(busy), int'(m_mode != 0));
      chk("irq", int'(irq), m_irq);
      chk("last_status", int'(last_status), m_last);
      chk("attempts", int'(attempts), m_att);
   endtask

   task automatic pulse_done(input logic [1:0] st);
      ibi_done = 1'b1; status = st;
      tick();
      ibi_done = 1'b0;
   endtask

   int gap;

   initial begin
      @(negedge clk);
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      chk("reset_busy", int'(busy), 0);
      chk("reset_attempts", int'(attempts), 0);
      chk("reset_begin", int'(ibi_begin), 0);

      // Successful IBI
      ibi_en = 1'b1; dav = 1'b1; pend = 1'b1; hold = HoldoffW'(10);
      tick();
      chk("ok_begin", int'(ibi_begin), 1);
      pend = 1'b0;
      tick();
      pulse_done(2'b00);
      chk("ok_irq", int'(irq), 1);
      chk("ok_idle", int'(busy), 0);
      chk("ok_attempts", int'(attempts), 0);
      tick();

      // NACK retries: done to next begin is H+3 cycles, attempts saturate at 3
      pend = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) begin
         pulse_done(2'b01);
         chk("nack_attempts", int'(attempts), (i < MaxAtt) ? i + 1 : MaxAtt);
         chk("nack_last", int'(last_status), 1);
         gap = 1;
         while (!ibi_begin && gap < 60) begin
            tick(); gap++;
         end
         chk("nack_gap", gap, 13);
      end
      pulse_done(2'b00);
      chk("recover_attempts", int'(attempts), 0);

      // Abort during IbiActive: fail once first so the clear is visible
      hold = '0;
      tick();
      pulse_done(2'b10);
      chk("pre_abort_attempts", int'(attempts), 1);
      tick(); tick();
      chk("restart_begin", int'(ibi_begin), 1);
      pend = 1'b0; abort = 1'b1;
      tick();
      abort = 1'b0;
      tick();
      pulse_done(2'b01);
      chk("abort_idle", int'(busy), 0);
      chk("abort_attempts", int'(attempts), 0);
      chk("abort_irq", int'(irq), 1);
      pend = 1'b1;
      tick();
      pulse_done(2'b01);
      chk("abort_flag_cleared", int'(busy), 1);
      pend = 1'b0;
      tick(); tick();

      // Spurious done in Idle, then abort coinciding with done
      pulse_done(2'b11);
      chk("spurious_irq", int'(irq), 0);
      pend = 1'b1;
      tick();
      pend = 1'b0; abort = 1'b1;
      pulse_done(2'b10);
      abort = 1'b0;
      chk("simul_irq", int'(irq), 1);
      chk("simul_idle", int'(busy), 0);
      chk("simul_last", int'(last_status), 2);

      // Reset in the middle of Holdoff
      pend = 1'b1; hold = HoldoffW'(10);
      tick();
      pend = 1'b0;
      pulse_done(2'b11);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_busy", int'(busy), 0);
      chk("rst_last", int'(last_status), 0);
      chk("rst_attempts", int'(attempts), 0);

      // Hot-Join request, re-entered after holdoff while still requested
      dav = 1'b0; hj_en = 1'b1; hj_req = 1'b1; hold = HoldoffW'(2);
      tick();
      chk("hj_begin", int'(hj_begin), HjOn ? 1 : 0);
      hj_done = 1'b1;
      tick();
      hj_done = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      chk("hj_reenter", int'(hj_begin), HjOn ? 1 : 0);
      hj_done = 1'b1;
      tick();
      hj_done = 1'b0; hj_req = 1'b0;
      for (int i = 0; i < 5; i++) tick();

      // Random phase
      for (int i = 0; i < 4000; i++) begin
         rst      = ($urandom_range(0, 299) == 0);
         abort    = ($urandom_range(0, 24) == 0);
         ibi_done = ($urandom_range(0, 3) == 0);
         hj_done  = ($urandom_range(0, 3) == 0);
         status   = 2'($urandom_range(0, 3));
         pend     = ($urandom_range(0, 1) == 0);
         hj_req   = ($urandom_range(0, 1) == 0);
         ibi_en   = ($urandom_range(0, 7) != 0);
         hj_en    = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 15) == 0) dav = ~dav;
         hold     = HoldoffW'($urandom_range(0, 6));
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
